// File: rtl/softlink_pkg.sv
// Shared defaults, FSM state type and small helpers for the softlink frame packer.
package softlink_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAME_LEN = 30;
    localparam int DEF_DEPTH     = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Only whole-word writes reach the buffer; partial writes are dropped.
    function automatic logic is_full_strobe(input logic [3:0] strb);
        return (strb == 4'hF);
    endfunction

endpackage

// File: rtl/softlink_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and an occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module softlink_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && (level != LVL_W'(DEPTH));
    assign pop_ok  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    // Storage is deliberately left unreset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/softlink_frame_packer.sv
// Buffers AXI-Lite element writes and releases them as FRAME_LEN-element
// AXI-Stream frames to the softmax core, with drop/overflow accounting.
module softlink_frame_packer
    import softlink_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [3:0]                 wr_strb,
    output logic                       wr_full,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                drop_cnt,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output state_t                     dbg_state
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             full;
    logic             push;
    logic             wr_drop;
    logic             ovf_set;
    logic             beat;
    logic             frame_ready;

    // Full is judged on the registered level only: a pop in the same cycle
    // never frees room for a write that arrives while full.
    assign full        = (level == LVL_W'(DEPTH));
    assign wr_full     = full;
    assign push        = wr_en && is_full_strobe(wr_strb) && !full;
    assign wr_drop     = wr_en && !push;
    assign ovf_set     = wr_en && full;
    assign frame_ready = (level >= LVL_W'(FRAME_LEN));

    // Stream handshake: a beat transfers on any edge where tvalid and tready
    // are both 1; tvalid never drops and tdata/tlast never change until then.
    assign beat      = m_axis_tvalid && m_axis_tready;
    assign dbg_state = state;

    softlink_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .push         (push),
        .din          (wr_data),
        .pop          (beat),
        .dout         (m_axis_tdata),
        .level        (level)
    );

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            COLLECT: begin
                if (frame_ready) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (idx == IDX_W'(FRAME_LEN - 1));
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        state_nxt = COLLECT;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state <= COLLECT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Overflow set takes priority over a simultaneous clear.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wr_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_softlink_frame_packer.sv
// Directed bench for softlink_frame_packer: framing, backpressure, overflow,
// strobe drops, streaming frames and reset mid-frame.
module tb_softlink_frame_packer;
    import softlink_pkg::*;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 30;
    localparam int DEPTH     = 32;
    localparam int LVL_W     = $clog2(DEPTH + 1);

    logic              S_AXI_ACLK = 1'b0;
    logic              S_AXI_ARESET;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_strb;
    logic              wr_full;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [LVL_W-1:0]  level;
    logic [15:0]       drop_cnt;
    logic              ovf;
    logic              ovf_clr;
    state_t            dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] beat_data_q[$];
    logic              beat_last_q[$];
    int                beat_edge_q[$];

    softlink_frame_packer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .DEPTH     (DEPTH)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_full       (wr_full),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .level         (level),
        .drop_cnt      (drop_cnt),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr),
        .dbg_state     (dbg_state)
    );

    // Clock / reset block
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

    // Inputs are stable at the falling edge, so a handshake seen here is the
    // beat that completes on the following rising edge (numbered cyc+1).
    always @(negedge S_AXI_ACLK) begin
        if (!S_AXI_ARESET && m_axis_tvalid && m_axis_tready) begin
            beat_data_q.push_back(m_axis_tdata);
            beat_last_q.push_back(m_axis_tlast);
            beat_edge_q.push_back(cyc + 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        beat_data_q.delete();
        beat_last_q.delete();
        beat_edge_q.delete();
    endtask

    task automatic apply_reset();
        S_AXI_ARESET  = 1'b1;
        wr_en         = 1'b0;
        wr_data       = '0;
        wr_strb       = 4'h0;
        m_axis_tready = 1'b0;
        ovf_clr       = 1'b0;
        tick();
        tick();
        S_AXI_ARESET = 1'b0;
        clear_queues();
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d, input logic [3:0] s, output int acc_edge);
        wr_en    = 1'b1;
        wr_data  = d;
        wr_strb  = s;
        acc_edge = cyc + 1;
        tick();
        wr_en   = 1'b0;
        wr_strb = 4'h0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit done);
        int cnt = 0;
        while (beat_data_q.size() < n && cnt < budget) begin
            tick();
            cnt++;
        end
        done = (beat_data_q.size() >= n);
    endtask

    // Scenarios
    task automatic test_reset();
        apply_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got %b expected 0", wr_full); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (dbg_state !== COLLECT) begin errors++; $display("FAIL reset_state: got %0d expected COLLECT", dbg_state); end
    endtask

    task automatic test_nominal_frame();
        int last_edge;
        bit done;
        logic [DATA_W-1:0] d;
        apply_reset();
        m_axis_tready = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            d = 32'h4080_0000 + (k << 15);
            exp_q.push_back(d);
            write_word(d, 4'hF, last_edge);
        end
        wait_beats(FRAME_LEN, 100, done);
        checks++; if (!done) begin errors++; $display("FAIL nominal_timeout: got %0d beats expected %0d", beat_data_q.size(), FRAME_LEN); end
        checks++; if (beat_data_q.size() != FRAME_LEN) begin errors++; $display("FAIL nominal_count: got %0d expected %0d", beat_data_q.size(), FRAME_LEN); end
        for (int i = 0; i < beat_data_q.size() && i < FRAME_LEN; i++) begin
            checks++; if (beat_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL nominal_data[%0d]: got %h expected %h", i, beat_data_q[i], exp_q[i]); end
            checks++; if (beat_last_q[i] !== (i == FRAME_LEN - 1)) begin errors++; $display("FAIL nominal_tlast[%0d]: got %b expected %b", i, beat_last_q[i], (i == FRAME_LEN - 1)); end
        end
        if (beat_data_q.size() >= FRAME_LEN) begin
            checks++; if (beat_data_q[FRAME_LEN-1] !== 32'h408E_8000) begin errors++; $display("FAIL nominal_last_word: got %h expected 408e8000", beat_data_q[FRAME_LEN-1]); end
        end
        if (beat_edge_q.size() > 0) begin
            checks++; if (beat_edge_q[0] - last_edge != 2) begin errors++; $display("FAIL nominal_latency: got %0d expected 2", beat_edge_q[0] - last_edge); end
        end
        checks++; if (level !== '0) begin errors++; $display("FAIL nominal_level_end: got %0d expected 0", level); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL nominal_tvalid_end: got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_backpressure();
        int acc_edge;
        int cnt = 0;
        bit stall;
        logic [DATA_W-1:0] pd;
        logic pl;
        logic [DATA_W-1:0] d;
        apply_reset();
        for (int k = 0; k < FRAME_LEN; k++) begin
            d = 32'h3F00_0000 | k;
            exp_q.push_back(d);
            write_word(d, 4'hF, acc_edge);
        end
        while (beat_data_q.size() < FRAME_LEN && cnt < 200) begin
            m_axis_tready = ~m_axis_tready;
            stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            tick();
            cnt++;
            if (stall) begin
                checks++; if (m_axis_tdata !== pd) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", m_axis_tdata, pd); end
                checks++; if (m_axis_tlast !== pl) begin errors++; $display("FAIL bp_hold_tlast: got %b expected %b", m_axis_tlast, pl); end
            end
        end
        m_axis_tready = 1'b0;
        checks++; if (beat_data_q.size() != FRAME_LEN) begin errors++; $display("FAIL bp_count: got %0d expected %0d", beat_data_q.size(), FRAME_LEN); end
        for (int i = 0; i < beat_data_q.size() && i < FRAME_LEN; i++) begin
            checks++; if (beat_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, beat_data_q[i], exp_q[i]); end
            checks++; if (beat_last_q[i] !== (i == FRAME_LEN - 1)) begin errors++; $display("FAIL bp_tlast[%0d]: got %b expected %b", i, beat_last_q[i], (i == FRAME_LEN - 1)); end
        end
    endtask

    task automatic test_overflow();
        int acc_edge;
        apply_reset();
        for (int k = 0; k < DEPTH + 1; k++) begin
            write_word(32'hA000_0000 + k, 4'hF, acc_edge);
        end
        checks++; if (level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
        checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL ovf_wr_full: got %b expected 1", wr_full); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
        checks++; if (m_axis_tdata !== 32'hA000_0000) begin errors++; $display("FAIL ovf_head: got %h expected a0000000", m_axis_tdata); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_clear_drop_cnt: got %0d expected 1", drop_cnt); end
        ovf_clr = 1'b1;
        write_word(32'hBEEF_0000, 4'hF, acc_edge);
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ovf); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_set_wins_drop: got %0d expected 2", drop_cnt); end
        m_axis_tready = 1'b1;
        write_word(32'hDEAD_0000, 4'hF, acc_edge);
        m_axis_tready = 1'b0;
        checks++; if (level !== LVL_W'(DEPTH - 1)) begin errors++; $display("FAIL ovf_no_passthru_level: got %0d expected %0d", level, DEPTH - 1); end
        checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_no_passthru_drop: got %0d expected 3", drop_cnt); end
        checks++; if (m_axis_tdata !== 32'hA000_0001) begin errors++; $display("FAIL ovf_no_passthru_head: got %h expected a0000001", m_axis_tdata); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL ovf_no_passthru_full: got %b expected 0", wr_full); end
    endtask

    task automatic test_partial_strobe();
        int acc_edge;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            write_word(32'h1111_0000 + k, 4'hF, acc_edge);
        end
        write_word(32'h2222_0000, 4'h3, acc_edge);
        checks++; if (level !== LVL_W'(3)) begin errors++; $display("FAIL strb_level: got %0d expected 3", level); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL strb_drop_cnt: got %0d expected 1", drop_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL strb_ovf: got %b expected 0", ovf); end
        write_word(32'h3333_0000, 4'hE, acc_edge);
        checks++; if (level !== LVL_W'(3)) begin errors++; $display("FAIL strb_level2: got %0d expected 3", level); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL strb_drop_cnt2: got %0d expected 2", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        int acc_edge;
        bit done;
        logic [DATA_W-1:0] d;
        apply_reset();
        m_axis_tready = 1'b1;
        for (int k = 0; k < 2 * FRAME_LEN; k++) begin
            d = 32'h4080_0000 + (k << 15);
            exp_q.push_back(d);
            write_word(d, 4'hF, acc_edge);
        end
        wait_beats(2 * FRAME_LEN, 200, done);
        checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: got %0d beats expected %0d", beat_data_q.size(), 2 * FRAME_LEN); end
        checks++; if (beat_data_q.size() != 2 * FRAME_LEN) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", beat_data_q.size(), 2 * FRAME_LEN); end
        for (int i = 0; i < beat_data_q.size() && i < 2 * FRAME_LEN; i++) begin
            checks++; if (beat_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, beat_data_q[i], exp_q[i]); end
            checks++; if (beat_last_q[i] !== (i == FRAME_LEN - 1 || i == 2 * FRAME_LEN - 1)) begin errors++; $display("FAIL b2b_tlast[%0d]: got %b", i, beat_last_q[i]); end
            if (i > 0) begin
                checks++;
                if (beat_edge_q[i] - beat_edge_q[i-1] != ((i == FRAME_LEN) ? 2 : 1)) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, beat_edge_q[i] - beat_edge_q[i-1], (i == FRAME_LEN) ? 2 : 1);
                end
            end
        end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (level !== '0) begin errors++; $display("FAIL b2b_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_reset_mid_drain();
        int acc_edge;
        bit done;
        logic [DATA_W-1:0] d;
        apply_reset();
        write_word(32'h5555_0000, 4'h1, acc_edge);
        m_axis_tready = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            write_word(32'h7700_0000 + k, 4'hF, acc_edge);
        end
        wait_beats(10, 100, done);
        checks++; if (!done) begin errors++; $display("FAIL rst_mid_timeout: got %0d beats expected 10", beat_data_q.size()); end
        S_AXI_ARESET = 1'b1;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_mid_level: got %0d expected 0", level); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (dbg_state !== COLLECT) begin errors++; $display("FAIL rst_mid_state: got %0d expected COLLECT", dbg_state); end
        S_AXI_ARESET = 1'b0;
        clear_queues();
        for (int k = 0; k < FRAME_LEN; k++) begin
            d = 32'h3F80_0000 + k;
            exp_q.push_back(d);
            write_word(d, 4'hF, acc_edge);
        end
        wait_beats(FRAME_LEN, 100, done);
        checks++; if (beat_data_q.size() != FRAME_LEN) begin errors++; $display("FAIL rst_mid_count: got %0d expected %0d", beat_data_q.size(), FRAME_LEN); end
        for (int i = 0; i < beat_data_q.size() && i < FRAME_LEN; i++) begin
            checks++; if (beat_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_data[%0d]: got %h expected %h", i, beat_data_q[i], exp_q[i]); end
            checks++; if (beat_last_q[i] !== (i == FRAME_LEN - 1)) begin errors++; $display("FAIL rst_mid_tlast[%0d]: got %b", i, beat_last_q[i]); end
        end
        m_axis_tready = 1'b0;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_nominal_frame();
        test_backpressure();
        test_overflow();
        test_partial_strobe();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softlink_frame_packer.md
SOFTLINK_FRAME_PACKER -- requirements
Module: softlink_frame_packer

Interface
REQ-001 Parameter DATA_W, default 32, width of one float32 element.
REQ-002 Parameter FRAME_LEN, default 30, number of elements in one softmax input vector.
REQ-003 Parameter DEPTH, default 32, buffer entries; must be at least FRAME_LEN.
REQ-004 The block SHALL have one clock, S_AXI_ACLK. Reset is S_AXI_ARESET: synchronous and active-high.
REQ-005 S_AXI_ACLK  in  1  rising-edge clock, shared with the AXI-Lite slave.
REQ-006 S_AXI_ARESET  in  1  synchronous active-high reset.
REQ-007 wr_en  in  1  one-cycle strobe from the AXI-Lite slave per accepted write to offset 0x0.
REQ-008 wr_data  in  DATA_W  written word (float32 bit pattern).
REQ-009 wr_strb  in  4  byte strobes of that write.
REQ-010 wr_full  out  1  buffer full; the slave uses it to stall BVALID.
REQ-011 m_axis_tdata  out  DATA_W  element to the softmax core.
REQ-012 m_axis_tvalid  out  1  element valid.
REQ-013 m_axis_tready  in  1  softmax core accepts the element.
REQ-014 m_axis_tlast  out  1  last element of the frame.
REQ-015 level  out  $clog2(DEPTH+1)  number of words buffered.
REQ-016 drop_cnt  out  16  count of dropped writes; saturates at 0xFFFF.
REQ-017 ovf  out  1  sticky overflow flag.
REQ-018 ovf_clr  in  1  clears ovf.

Function
REQ-019 A write SHALL be accepted when wr_en=1, wr_strb=4'hF and level<DEPTH at that clock edge; the word is stored in FIFO order and level rises by 1 at the next edge.
REQ-020 When wr_en=1 and wr_strb!=4'hF, the write SHALL be dropped and drop_cnt incremented; ovf is unchanged.
REQ-021 When wr_en=1 and level==DEPTH, the write SHALL be dropped, drop_cnt incremented and ovf set, even if a pop happens in the same cycle (no pass-through when full).
REQ-022 wr_full SHALL equal (level==DEPTH), decoded combinationally from the registered level.
REQ-023 The FSM SHALL have two states, COLLECT and DRAIN.
  - COLLECT: m_axis_tvalid=0. Go to DRAIN at the next edge once level>=FRAME_LEN.
  - DRAIN: m_axis_tvalid=1; m_axis_tdata is the FIFO head.
REQ-024 In DRAIN, a beat occurs when tvalid and tready are both 1 at an edge. Each beat pops one word and increments beat index idx (0..FRAME_LEN-1).
REQ-025 m_axis_tlast SHALL be 1 exactly when state==DRAIN and idx==FRAME_LEN-1.
REQ-026 The tlast beat SHALL return the FSM to COLLECT and clear idx. If level is still >=FRAME_LEN, the next frame re-enters DRAIN one cycle later (one idle cycle between frames).
REQ-027 While tready=0 in DRAIN, tdata, tlast and idx SHALL hold stable.
REQ-028 An accepted write and a pop in the same cycle SHALL leave level unchanged and keep ordering intact.
REQ-029 Latency: with tready=1, the first beat SHALL occur 2 cycles after the edge that accepts the FRAME_LEN-th write.
REQ-030 ovf_clr and an overflow drop in the same cycle: the set SHALL win.
REQ-031 Pointers wrap modulo DEPTH; DEPTH is not required to be a power of two.

Reset
REQ-032 While S_AXI_ARESET=1 at an edge, the following SHALL be forced; this includes reset mid-DRAIN, where the buffered data is discarded:
  - state=COLLECT, idx=0, pointers=0, level=0;
  - drop_cnt=0, ovf=0;
  - m_axis_tvalid=0, m_axis_tlast=0, wr_full=0.
REQ-033 m_axis_tdata is don't-care after reset; buffer memory is not reset.

Structure
REQ-034 Package softlink_pkg SHALL hold DATA_W, FRAME_LEN, DEPTH defaults and the state enum {COLLECT, DRAIN}.
REQ-035 Storage SHALL be a sub-module softlink_sync_fifo with first-word-fall-through head, level output, and push/pop ports. The FSM, counters and flags live in softlink_frame_packer.

Verification
REQ-036 Nominal frame: tready=1, 30 full-strobe writes of 0x40800000+(k<<15), k=0..29 -> 30 beats in order, first 2 cycles after the 30th write, tlast only on 0x408E8000, level back to 0.
REQ-037 Backpressure: tready toggled 1/0 each cycle during a frame -> 30 beats, no data change while stalled, tlast on beat 29.
REQ-038 Overflow: tready=0, 33 writes -> level=32, wr_full=1, drop_cnt=1, ovf=1; ovf_clr pulse -> ovf=0, drop_cnt stays 1.
REQ-039 Partial strobe: write with wr_strb=4'h3 -> level unchanged, drop_cnt+1, ovf=0.
REQ-040 Concurrent traffic: 60 writes streamed while draining -> two frames, tlast on elements 29 and 59, one idle cycle between frames, no drops.
REQ-041 Reset mid-DRAIN after 10 beats -> next cycle tvalid=0, level=0, drop_cnt=0; then 30 new writes produce a clean frame starting at the new k=0 data.
